// File: rtl/reg_file.sv
// RISC-V integer register file: 32 x 32-bit, x0 hardwired to zero, two combinational
// read ports and one synchronous write port. Optional forwarding under REGFILE_BYPASS_EN.
module reg_file #(
  parameter logic [31:0] SP_INIT = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic        rd_wren,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o
);

  // x0 has no storage; reads of index 0 are forced to zero below.
  logic [31:0] regs [1:31];
  logic        wr_en;

  assign wr_en = rd_wren && (rd_addr != 5'd0);

  // Reset dominates any write presented at the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= (i == 2) ? SP_INIT : 32'h0;
      end
    end else if (wr_en) begin
      regs[rd_addr] <= rd_data;
    end
  end

  always_comb begin
    rs1_data_o = 32'h0;
    rs2_data_o = 32'h0;
    if (rs1_addr != 5'd0) rs1_data_o = regs[rs1_addr];
    if (rs2_addr != 5'd0) rs2_data_o = regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write so a same-cycle reader sees the new value.
    if (wr_en && rst && (rs1_addr == rd_addr)) rs1_data_o = rd_data;
    if (wr_en && rst && (rs2_addr == rd_addr)) rs2_data_o = rd_data;
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, bypass corner case,
// then randomized traffic against an array-based register model.
module tb_reg_file;

  localparam logic [31:0] SP_INIT = 32'h0000_0800;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        rd_wren;
  logic [31:0] rd_data;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model [32];

  typedef struct {
    logic        rst;
    logic        wren;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [6];

  reg_file #(.SP_INIT(SP_INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .rd_wren    (rd_wren),
    .rd_data    (rd_data),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic read_check(input string name, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [31:0] e1, input logic [31:0] e2);
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
    check({name, "_rs1"}, rs1_data_o, e1);
    check({name, "_rs2"}, rs2_data_o, e2);
  endtask

  task automatic idle();
    rst = 1'b1;
    rd_wren = 1'b0;
    rd_addr = 5'd0;
    rd_data = 32'h0;
  endtask

  // Expected read value from the model and the inputs currently presented.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYPASS && rd_wren && rst && rd_addr != 5'd0 && a == rd_addr) return rd_data;
    return model[a];
  endfunction

  task automatic model_edge();
    if (!rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[2] = SP_INIT;
    end else if (rd_wren && rd_addr != 5'd0) begin
      model[rd_addr] = rd_data;
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 5'd1, 32'hAAAA_BBBB, 5'd1, 5'd3, 32'hAAAA_BBBB, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 5'd3, 32'h1234_5678, 5'd1, 5'd3, 32'hAAAA_BBBB, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd1, 32'h0, 32'hAAAA_BBBB};
    vecs[3] = '{1'b1, 1'b0, 5'd4, 32'hDEAD_BEEF, 5'd4, 5'd3, 32'h0, 32'h1234_5678};
    vecs[4] = '{1'b0, 1'b1, 5'd5, 32'h0000_CAFE, 5'd5, 5'd2, 32'h0, SP_INIT};
    vecs[5] = '{1'b1, 1'b1, 5'd5, 32'h0000_CAFE, 5'd5, 5'd1, 32'h0000_CAFE, 32'h0};

    idle();
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;

    // reset for two edges
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    read_check("reset_sp_x0", 5'd2, 5'd0, SP_INIT, 32'h0);
    read_check("reset_x1_x31", 5'd1, 5'd31, 32'h0, 32'h0);

    // table-driven directed vectors: apply one edge, then read back idle
    for (int i = 0; i < 6; i++) begin
      rst = vecs[i].rst;
      rd_wren = vecs[i].wren;
      rd_addr = vecs[i].rd;
      rd_data = vecs[i].data;
      tick();
      idle();
      read_check($sformatf("vec%0d", i), vecs[i].r1, vecs[i].r2, vecs[i].e1, vecs[i].e2);
    end

    // same-cycle read of the register being written
    rd_wren = 1'b1;
    rd_addr = 5'd7;
    rd_data = 32'h1122_3344;
    read_check("x7_pre_edge", 5'd7, 5'd7, BYPASS ? 32'h1122_3344 : 32'h0,
               BYPASS ? 32'h1122_3344 : 32'h0);
    tick();
    idle();
    read_check("x7_post_edge", 5'd7, 5'd7, 32'h1122_3344, 32'h1122_3344);

    // reset held with a write pending: write lost, registers initialised
    rst = 1'b0;
    rd_wren = 1'b1;
    rd_addr = 5'd7;
    rd_data = 32'h5555_5555;
    tick();
    tick();
    idle();
    read_check("reset_held", 5'd7, 5'd2, 32'h0, SP_INIT);

    // randomized traffic against the model (state is post-reset here)
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[2] = SP_INIT;
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 19) != 0);
      rd_wren = $urandom_range(0, 1);
      rd_addr = (($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      rd_data = $urandom;
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = (($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31)));
      exp_q.push_back(model_read(rs1_addr));
      exp_q.push_back(model_read(rs2_addr));
      #1;
      check("rand_rs1", rs1_data_o, exp_q.pop_front());
      check("rand_rs2", rs2_data_o, exp_q.pop_front());
      model_edge();
      tick();
    end

    // final sweep of every register
    idle();
    for (int a = 0; a < 32; a++) begin
      read_check($sformatf("sweep_x%0d", a), 5'(a), 5'(31 - a), model[a], model[31 - a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
